// File: rtl/spart_bus_responder.sv
// spart_bus_responder: SPART bus decode, baud generator, 8N1 TX/RX with 16x oversampling.
// Define SPART_LOOPBACK_EN to add the command-register loopback (internal TX line feeds RX).
module spart_bus_responder #(
  parameter logic [15:0] RST_DIVISOR = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  input  logic       rxd,
  output logic       txd
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_tst, w_tst_nx, r_rst, w_rst_nx;
  logic [15:0] r_div, r_cnt;
  logic [7:0] r_hi, r_txbuf, r_tsh, r_rsh, r_rxbuf, w_rdata;
  logic [3:0] r_tbc, r_rbc;
  logic [2:0] r_tidx, r_ridx;
  logic r_pend, r_rda, r_ovr, r_s1, r_s2, r_s3;
  logic w_wr, w_rd_buf, w_rd_st, w_tick, w_tbit, w_rbit, w_rsamp, w_done, w_fall, w_txl, w_rxin, w_lb;
  assign w_wr = iocs && !iorw;
  assign w_rd_buf = iocs && iorw && ioaddr == 2'b00;
  assign w_rd_st = iocs && iorw && ioaddr == 2'b01;
  assign w_tick = r_cnt == 16'd0;
  assign w_tbit = w_tick && r_tbc == 4'd15;
  assign w_rbit = w_tick && r_rbc == 4'd15;
  assign w_rsamp = w_tick && r_rbc == 4'd7;
  assign w_fall = r_s3 && !r_s2;
  assign w_done = r_rst == STOP && w_rsamp && r_s2;
  assign w_rxin = w_lb ? w_txl : rxd;
  assign rda = r_rda;
  assign w_rdata = ioaddr[0] ? {4'd0, w_lb, r_ovr, r_rda, tbr} : r_rxbuf;
  assign databus = (iocs && iorw && !ioaddr[1]) ? w_rdata : 8'hzz;
`ifdef SPART_LOOPBACK_EN
  logic r_lb;
  assign w_lb = r_lb;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lb <= 1'b0;
    else if (w_wr && ioaddr == 2'b01) r_lb <= databus[0];
`else
  assign w_lb = 1'b0;
`endif
  // a low-byte write commits the divisor and restarts the tick period at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= RST_DIVISOR;
      r_hi <= RST_DIVISOR[15:8];
      r_cnt <= RST_DIVISOR;
    end else begin
      if (w_wr && ioaddr == 2'b11) r_hi <= databus;
      if (w_wr && ioaddr == 2'b10) begin
        r_div <= {r_hi, databus};
        r_cnt <= {r_hi, databus};
      end else r_cnt <= w_tick ? r_div : r_cnt - 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tst <= IDLE;
    else r_tst <= w_tst_nx;
  always_comb begin
    w_tst_nx = r_tst;
    case (r_tst)
      IDLE:  if (r_pend && w_tick) w_tst_nx = START;
      START: if (w_tbit) w_tst_nx = DATA;
      DATA:  if (w_tbit && r_tidx == 3'd7) w_tst_nx = STOP;
      STOP:  if (w_tbit) w_tst_nx = IDLE;
    endcase
  end
  always_comb begin
    w_txl = r_tst == START ? 1'b0 : r_tst == DATA ? r_tsh[0] : 1'b1;
    txd = w_lb ? 1'b1 : w_txl;
    tbr = r_tst == IDLE && !r_pend;
  end
  // a loaded byte waits in r_txbuf until the next tick starts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_txbuf <= 8'd0;
      r_tsh <= 8'd0;
      r_tbc <= 4'd0;
      r_tidx <= 3'd0;
    end else begin
      if (w_wr && ioaddr == 2'b00 && tbr) begin
        r_txbuf <= databus;
        r_pend <= 1'b1;
      end else if (r_tst == IDLE && r_pend && w_tick) begin
        r_pend <= 1'b0;
        r_tsh <= r_txbuf;
      end
      r_tbc <= r_tst == IDLE ? 4'd0 : r_tbc + {3'd0, w_tick};
      if (r_tst == DATA && w_tbit) begin
        r_tsh <= r_tsh >> 1;
        r_tidx <= r_tidx + 3'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rst <= IDLE;
    else r_rst <= w_rst_nx;
  always_comb begin
    w_rst_nx = r_rst;
    case (r_rst)
      IDLE:  if (w_fall) w_rst_nx = START;
      START: w_rst_nx = (w_rsamp && r_s2) ? IDLE : w_rbit ? DATA : START;
      DATA:  if (w_rbit && r_ridx == 3'd7) w_rst_nx = STOP;
      STOP:  if (w_rsamp) w_rst_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_s1, r_s2, r_s3} <= 3'b111;
      r_rbc <= 4'd0;
      r_ridx <= 3'd0;
      r_rsh <= 8'd0;
      r_rxbuf <= 8'd0;
      r_rda <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      {r_s1, r_s2, r_s3} <= {w_rxin, r_s1, r_s2};
      r_rbc <= r_rst == IDLE ? 4'd0 : r_rbc + {3'd0, w_tick};
      if (r_rst == DATA && w_rsamp) r_rsh <= {r_s2, r_rsh[7:1]};
      if (r_rst == DATA && w_rbit) r_ridx <= r_ridx + 3'd1;
      if (w_done) r_rxbuf <= r_rsh;
      r_rda <= w_done || (r_rda && !w_rd_buf);
      r_ovr <= (w_done && r_rda) || (r_ovr && !w_rd_st);
    end
  end
endmodule
